// File: rtl/encrypt_arbiter.sv
// Two-requester arbiter in front of a fixed-latency byte encryption unit.
// Grants one byte per cycle, tags each issue with {issued, requester, key slot}
// and routes the unit's result back to the right requester LAT cycles later.
// Build option: define ENCRYPT_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// always wins); otherwise contention is resolved round-robin.
module encrypt_arbiter #(
    parameter int LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_data,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_data,
    output logic [1:0] rsp_key_idx,
    output logic       enc_en,
    output logic [7:0] enc_din,
    input  logic       enc_v,
    input  logic [7:0] enc_dout,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         key_q, key_d;
    logic               err_q, err_d;
    logic [LAT-1:0]     tag_issued_q, tag_issued_d;
    logic [LAT-1:0]     tag_id_q, tag_id_d;
    logic [LAT-1:0][1:0] tag_slot_q, tag_slot_d;

    logic grant0, grant1, grant_any;
    logic out_issued, out_id, rsp_fire;
    logic [1:0] out_slot;

`ifdef ENCRYPT_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 only gets the unit when requester 0 is silent.
    always_comb begin
        grant0 = rst & req0_valid;
        grant1 = rst & req1_valid & ~req0_valid;
    end
`else
    logic rr_q, rr_d;

    // Round-robin: rr_q set means requester 1 wins the next contention.
    always_comb begin
        grant0 = rst & req0_valid & (~req1_valid | ~rr_q);
        grant1 = rst & req1_valid & (~req0_valid | rr_q);
        rr_d   = rr_q;
        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end
    end

    // Pointer register; reset favours requester 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Handshake and encrypt-unit drive; din is forced to zero when nothing is issued.
    always_comb begin
        grant_any  = grant0 | grant1;
        req0_ready = grant0;
        req1_ready = grant1;
        enc_en     = grant_any;
        enc_din    = 8'h00;
        if (grant0) begin
            enc_din = req0_data;
        end else if (grant1) begin
            enc_din = req1_data;
        end
    end

    // Key slot advances once per issued byte and wraps 2 -> 0.
    always_comb begin
        key_d = key_q;
        if (grant_any) begin
            key_d = (key_q == 2'd2) ? 2'd0 : key_q + 2'd1;
        end
    end

    // Tag shift register mirroring the unit's latency; stage LAT-1 lines up with enc_v.
    always_comb begin
        tag_issued_d = tag_issued_q;
        tag_id_d     = tag_id_q;
        tag_slot_d   = tag_slot_q;
        for (int i = LAT - 1; i > 0; i--) begin
            tag_issued_d[i] = tag_issued_q[i-1];
            tag_id_d[i]     = tag_id_q[i-1];
            tag_slot_d[i]   = tag_slot_q[i-1];
        end
        tag_issued_d[0] = grant_any;
        tag_id_d[0]     = grant1;
        tag_slot_d[0]   = key_q;
    end

    // Response routing plus sticky detection of enc_v disagreeing with the tag.
    always_comb begin
        out_issued  = tag_issued_q[LAT-1];
        out_id      = tag_id_q[LAT-1];
        out_slot    = tag_slot_q[LAT-1];
        rsp_fire    = out_issued & enc_v;
        rsp0_valid  = rsp_fire & ~out_id;
        rsp1_valid  = rsp_fire & out_id;
        rsp0_data   = rsp0_valid ? enc_dout : 8'h00;
        rsp1_data   = rsp1_valid ? enc_dout : 8'h00;
        rsp_key_idx = rsp_fire ? out_slot : 2'd0;
        err_d       = err_q | (enc_v != out_issued);
        err         = err_q;
    end

    // Activity FSM: DRAIN covers the tail where tags are still in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_any) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (grant_any)          state_d = ACTIVE;
                else if (|tag_issued_q) state_d = DRAIN;
                else                    state_d = IDLE;
            end
            DRAIN: begin
                if (grant_any)          state_d = ACTIVE;
                else if (!(|tag_issued_q)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy = (state_q == ACTIVE) || (state_q == DRAIN);
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            key_q        <= 2'd0;
            err_q        <= 1'b0;
            tag_issued_q <= '0;
            tag_id_q     <= '0;
            tag_slot_q   <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            err_q        <= err_d;
            tag_issued_q <= tag_issued_d;
            tag_id_q     <= tag_id_d;
            tag_slot_q   <= tag_slot_d;
        end
    end

endmodule

// File: doc/encrypt_arbiter.md
ENCRYPT_ARBITER -- requirements
Module: encrypt_arbiter

Interface
REQ-001 Parameter LAT, default 2, SHALL be the fixed encrypt_unit latency in cycles from en/din sampled to v/dout.
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N offers a byte.
REQ-005 req0_data / req1_data  input  8  plaintext byte from requester N.
REQ-006 req0_ready / req1_ready  output  1  byte accepted this cycle (valid & ready = transfer).
REQ-007 rsp0_valid / rsp1_valid  output  1  encrypted byte for requester N, one-cycle pulse, no backpressure.
REQ-008 rsp0_data / rsp1_data  output  8  encrypted byte for requester N.
REQ-009 rsp_key_idx  output  2  key slot (0,1,2) used for the byte currently on rsp0/rsp1.
REQ-010 enc_en  output  1  drives encrypt_unit en.
REQ-011 enc_din  output  8  drives encrypt_unit din.
REQ-012 enc_v  input  1  encrypt_unit v.
REQ-013 enc_dout  input  8  encrypt_unit dout.
REQ-014 busy  output  1  high in ACTIVE or DRAIN.
REQ-015 err  output  1  sticky protocol-mismatch flag.

Function
REQ-016 Arbiter SHALL grant at most one requester per cycle; ready SHALL be high only for the granted requester, combinationally from valid and arbitration state.
REQ-017 Default policy SHALL be round-robin: on contention, grant the requester not granted most recently; after reset, requester 0 wins first contention.
REQ-018 Single requesting channel SHALL be granted every cycle (full throughput, one byte/cycle).
REQ-019 In a grant cycle enc_en SHALL be 1 and enc_din SHALL equal granted reqN_data; otherwise enc_en SHALL be 0 and enc_din SHALL be 8'h00.
REQ-020 A LAT-deep tag pipeline SHALL record {issued, requester id, key slot} per cycle.
REQ-021 Key slot counter SHALL start at 0, increment once per grant, wrap 2 -> 0, and SHALL NOT advance in idle cycles.
REQ-022 LAT cycles after a grant, enc_dout SHALL be routed to rspN_data of the tagged requester, rspN_valid pulsed, rsp_key_idx set to tagged slot; other channel's rsp_valid SHALL be 0.
REQ-023 rspN_data SHALL be 8'h00 when rspN_valid is 0.
REQ-024 FSM states IDLE, ACTIVE, DRAIN: IDLE->ACTIVE on any grant; ACTIVE stays while grants continue; ACTIVE->DRAIN on first cycle with no grant and tags in flight; DRAIN->ACTIVE on new grant; DRAIN->IDLE when pipeline empty.
REQ-025 err SHALL set when enc_v differs from tag-pipeline issued bit at the output stage, and SHALL hold until reset.
REQ-026 Grant and response in the same cycle SHALL both proceed independently.
REQ-027 Requester dropping valid without transfer SHALL not be an error; data is only consumed on valid & ready.

Reset
REQ-028 On rst low, asynchronously: all ready, rsp_valid, enc_en, busy, err = 0; all data outputs, rsp_key_idx = 0; key slot = 0; tag pipeline cleared; FSM = IDLE; round-robin pointer favours requester 0.
REQ-029 Reset mid-operation SHALL discard in-flight tags; no rsp_valid SHALL be produced for bytes granted before reset.

Configuration
REQ-030 Macro ENCRYPT_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win contention (fixed priority); requester 1 only granted when req0_valid is 0.
REQ-031 Macro undefined: round-robin per REQ-017; all other requirements unchanged in both builds.

Verification
REQ-032 Only req0_valid high with bytes 8'h11,8'h22,8'h33,8'h44 back-to-back -> enc_en high 4 cycles, rsp0_valid pulses LAT cycles later, rsp_key_idx 0,1,2,0, rsp1_valid never high.
REQ-033 Both valid continuously for 6 cycles (round-robin build) -> grants 0,1,0,1,0,1; responses alternate rsp0/rsp1 with matching key slots 0,1,2,0,1,2.
REQ-034 Same stimulus with ENCRYPT_ARB_FIXED_PRIO_EN -> all 6 grants to requester 0, req1_ready stays 0.
REQ-035 Single byte then idle -> FSM IDLE->ACTIVE->DRAIN->IDLE, busy high exactly 1+LAT cycles, key slot remains 1 during idle.
REQ-036 Force enc_v high with no byte in flight -> err rises next cycle and stays 1 until rst low.
REQ-037 Assert rst low with 2 bytes in flight -> all outputs 0 immediately, no rsp_valid after release, next grant uses key slot 0.
